// File: rtl/rotfind_pkg.sv
// Shared definitions for the rotation amount finder: default word width,
// derived amount width and the controller state encoding.
package rotfind_pkg;

  localparam int unsigned ROTFIND_WIDTH = 16;
  localparam int unsigned ROTFIND_AW    = $clog2(ROTFIND_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } rotfind_state_e;

endpackage

// File: rtl/rotfind_ctrl.sv
// Controller for the rotation amount finder: handshake FSM, step counter
// and the registered result outputs.
module rotfind_ctrl
  import rotfind_pkg::*;
#(
  parameter int unsigned WIDTH = ROTFIND_WIDTH,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          match_i,
  output logic          load_o,
  output logic          step_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          found_o,
  output logic [AW-1:0] amt_r_o,
  output logic [AW-1:0] amt_l_o
);

  localparam logic [AW-1:0] K_LAST = AW'(WIDTH - 1);

  rotfind_state_e state_q;
  logic [AW-1:0]  k_q;
  logic           busy_q;
  logic           done_q;
  logic           found_q;
  logic [AW-1:0]  amt_r_q;
  logic [AW-1:0]  amt_l_q;
  logic           last_s;

  assign last_s = (k_q == K_LAST);
  assign load_o = (state_q == ST_IDLE) && start_i;
  assign step_o = (state_q == ST_SEARCH) && !match_i && !last_s;

  // Handshake FSM, step counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      amt_r_q <= '0;
      amt_l_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= ST_SEARCH;
            busy_q  <= 1'b1;
            k_q     <= '0;
          end
        end
        ST_SEARCH: begin
          if (match_i) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            found_q <= 1'b1;
            amt_r_q <= k_q;
            // Modulo-WIDTH negate: k=0 wraps back to 0 in AW bits
            amt_l_q <= AW'(0) - k_q;
          end else if (last_s) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            found_q <= 1'b0;
            amt_r_q <= '0;
            amt_l_q <= '0;
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign found_o = found_q;
  assign amt_r_o = amt_r_q;
  assign amt_l_o = amt_l_q;

endmodule

// File: rtl/rotation_amount_finder_16.sv
// Sequential inverse of the rotate shifter: finds the smallest right-rotation
// amount taking a to y, one rotation step per clock.
module rotation_amount_finder_16
  import rotfind_pkg::*;
#(
  parameter int unsigned WIDTH = ROTFIND_WIDTH,
  parameter int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [AW-1:0]    amt_r,
  output logic [AW-1:0]    amt_l
);

  logic [WIDTH-1:0] rot_q;
  logic [WIDTH-1:0] rot_d;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] tgt_d;
  logic             load_s;
  logic             step_s;
  logic             match_s;

  assign match_s = (rot_q == tgt_q);

  rotfind_ctrl #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .match_i (match_s),
    .load_o  (load_s),
    .step_o  (step_s),
    .busy_o  (busy),
    .done_o  (done),
    .found_o (found),
    .amt_r_o (amt_r),
    .amt_l_o (amt_l)
  );

  // Next-state for the working word and captured target
  always_comb begin
    rot_d = rot_q;
    tgt_d = tgt_q;
    if (load_s) begin
      rot_d = a;
      tgt_d = y;
    end else if (step_s) begin
      rot_d = {rot_q[0], rot_q[WIDTH-1:1]};
    end else begin
      rot_d = rot_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= '0;
      tgt_q <= '0;
    end else begin
      rot_q <= rot_d;
      tgt_q <= tgt_d;
    end
  end

endmodule
